// File: rtl/frame_sync_descrambler.sv
// Frame-synchronised descrambler: hunts for SYNC_WORD, confirms lock over several frames and
// removes the x^15+x^14+1 additive keystream from each payload, reseeding at every frame boundary.
module frame_sync_descrambler #(
   parameter int                  SYNC_LEN   = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'h47,
   parameter int                  FRAME_LEN  = 1496,
   parameter logic [14:0]         LFSR_SEED  = 15'h57E5,
   parameter int                  LOCK_CNT   = 3,
   parameter int                  UNLOCK_CNT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic serial_in,
   output logic data_out,
   output logic data_valid,
   output logic frame_start,
   output logic locked,
   output logic sync_err
);

   localparam int POS_W   = $clog2(FRAME_LEN);
   localparam int WIN_W   = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t              state_r;
   logic [14:0]         lfsr_r;
   logic [SYNC_LEN-2:0] sr_r;
   logic [POS_W-1:0]    pos_r;
   logic                in_win_r;
   logic [WIN_W-1:0]    win_cnt_r;
   logic [MATCH_W-1:0]  match_r;
   logic [MISS_W-1:0]   miss_r;

   logic [SYNC_LEN-1:0] sr_next_s;
   logic                hit_s;
   logic                win_end_s;
   logic                pos_last_s;

   function automatic logic [14:0] lfsr_step(input logic [14:0] l);
      return {l[13:0], l[14] ^ l[13]};
   endfunction

   // Sync-word compare including the current bit, plus frame-position decodes.
   always_comb begin
      sr_next_s  = {sr_r, serial_in};
      hit_s      = (sr_next_s == SYNC_WORD);
      win_end_s  = in_win_r && (win_cnt_r == WIN_W'(SYNC_LEN - 1));
      pos_last_s = (pos_r == POS_W'(FRAME_LEN - 1));
   end

   // Framing FSM, keystream generator and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= HUNT;
         lfsr_r      <= LFSR_SEED;
         sr_r        <= '0;
         pos_r       <= '0;
         in_win_r    <= 1'b0;
         win_cnt_r   <= '0;
         match_r     <= '0;
         miss_r      <= '0;
         data_out    <= 1'b0;
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         data_out    <= 1'b0;
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
         if (in_valid) begin
            sr_r <= sr_next_s[SYNC_LEN-2:0];
            case (state_r)
               HUNT: begin
                  if (hit_s) begin
                     state_r   <= (LOCK_CNT == 1) ? LOCKED : CHECK;
                     locked    <= (LOCK_CNT == 1);
                     match_r   <= MATCH_W'(1);
                     miss_r    <= '0;
                     lfsr_r    <= LFSR_SEED;
                     pos_r     <= '0;
                     in_win_r  <= 1'b0;
                     win_cnt_r <= '0;
                  end
               end
               CHECK, LOCKED: begin
                  if (!in_win_r) begin
                     lfsr_r <= lfsr_step(lfsr_r);
                     if (state_r == LOCKED) begin
                        data_out    <= serial_in ^ lfsr_r[0];
                        data_valid  <= 1'b1;
                        frame_start <= (pos_r == POS_W'(0));
                     end
                     if (pos_last_s) begin
                        in_win_r  <= 1'b1;
                        win_cnt_r <= '0;
                     end else begin
                        pos_r <= pos_r + POS_W'(1);
                     end
                  end else if (!win_end_s) begin
                     win_cnt_r <= win_cnt_r + WIN_W'(1);
                  end else begin
                     // Frame boundary: always reseed so a locked receiver flywheels over a bad sync.
                     in_win_r  <= 1'b0;
                     win_cnt_r <= '0;
                     pos_r     <= '0;
                     lfsr_r    <= LFSR_SEED;
                     if (state_r == CHECK) begin
                        if (hit_s) begin
                           match_r <= match_r + MATCH_W'(1);
                           if ((match_r + MATCH_W'(1)) == MATCH_W'(LOCK_CNT)) begin
                              state_r <= LOCKED;
                              locked  <= 1'b1;
                              miss_r  <= '0;
                           end
                        end else begin
                           state_r <= HUNT;
                           match_r <= '0;
                        end
                     end else begin
                        if (hit_s) begin
                           miss_r <= '0;
                        end else begin
                           sync_err <= 1'b1;
                           if ((miss_r + MISS_W'(1)) == MISS_W'(UNLOCK_CNT)) begin
                              state_r <= HUNT;
                              locked  <= 1'b0;
                              miss_r  <= '0;
                              match_r <= '0;
                           end else begin
                              miss_r <= miss_r + MISS_W'(1);
                           end
                        end
                     end
                  end
               end
               default: begin
                  state_r <= HUNT;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_sync_descrambler.sv
// Self-checking bench: a transmit-side scrambler model builds frames, the expected receiver
// outputs for each beat are queued when the beat is driven and compared when the output registers.
module tb_frame_sync_descrambler;

   localparam int FRAME_LEN = 1496;
   localparam int SYNC_LEN  = 8;
   localparam int NFRM      = 16;

   logic clk;
   logic rst;
   logic in_valid;
   logic serial_in;
   logic data_out;
   logic data_valid;
   logic frame_start;
   logic locked;
   logic sync_err;

   int    total = 0;
   int    bad   = 0;
   string phase = "init";

   typedef struct {
      logic dv;
      logic d;
      logic fs;
      logic se;
      logic lk;
   } exp_t;

   typedef struct {
      bit [7:0] sync;
      bit       a5;
      bit       gaps;
      bit       lkb;
      bit       lka;
      bit       se;
      bit       rst_before;
      int       n_pay;
   } frame_t;

   exp_t   sb_q[$];
   frame_t tbl[NFRM];

   frame_sync_descrambler dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .serial_in   (serial_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_start (frame_start),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(string name, exp_t e);
      total++;
      if (data_valid !== e.dv || frame_start !== e.fs || sync_err !== e.se ||
          locked !== e.lk || (e.dv && data_out !== e.d)) begin
         bad++;
         $display("FAIL %s/%s t=%0t got dv=%b d=%b fs=%b se=%b lk=%b want dv=%b d=%b fs=%b se=%b lk=%b",
                  phase, name, $time, data_valid, data_out, frame_start, sync_err, locked,
                  e.dv, e.d, e.fs, e.se, e.lk);
      end
   endtask

   task automatic beat(logic v, logic b, exp_t e);
      exp_t got;
      @(negedge clk);
      in_valid  = v;
      serial_in = b;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check_out(v ? "beat" : "gap", got);
   endtask

   task automatic do_reset();
      exp_t z;
      z = '{dv:1'b0, d:1'b0, fs:1'b0, se:1'b0, lk:1'b0};
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      check_out("reset", z);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic gaps(bit en, logic lk);
      int n;
      n = 0;
      if (en) begin
         while ($urandom_range(0, 1) == 1 && n < 6) begin
            beat(1'b0, 1'($urandom_range(0, 1)), '{dv:1'b0, d:1'b0, fs:1'b0, se:1'b0, lk:lk});
            n++;
         end
      end
   endtask

   task automatic send_frame(frame_t f);
      logic [7:0]  s;
      logic [7:0]  pat;
      logic [14:0] tx_lfsr;
      logic        dbit;
      logic        last;
      exp_t        e;
      s   = f.sync;
      pat = 8'hA5;
      for (int i = 0; i < SYNC_LEN; i++) begin
         gaps(f.gaps, f.lkb);
         last = (i == SYNC_LEN - 1);
         e = '{dv:1'b0, d:1'b0, fs:1'b0, se:(last ? f.se : 1'b0), lk:(last ? f.lka : f.lkb)};
         beat(1'b1, s[7 - i], e);
      end
      tx_lfsr = 15'h57E5;
      for (int p = 0; p < f.n_pay; p++) begin
         gaps(f.gaps, f.lka);
         dbit    = f.a5 ? pat[7 - (p % 8)] : 1'b0;
         e       = '{dv:f.lka, d:dbit, fs:(f.lka && p == 0), se:1'b0, lk:f.lka};
         beat(1'b1, dbit ^ tx_lfsr[0], e);
         tx_lfsr = {tx_lfsr[13:0], tx_lfsr[14] ^ tx_lfsr[13]};
      end
   endtask

   initial begin
      logic [7:0] sw;
      exp_t       z;

      rst       = 1'b0;
      in_valid  = 1'b0;
      serial_in = 1'b0;

      //            sync   a5    gaps  lkb   lka   se    rst   n_pay
      tbl[0]  = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FRAME_LEN};
      tbl[1]  = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRAME_LEN};
      tbl[2]  = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[3]  = '{8'h47, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[4]  = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[5]  = '{8'h46, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, FRAME_LEN};
      tbl[6]  = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[7]  = '{8'h46, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, FRAME_LEN};
      tbl[8]  = '{8'h46, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, FRAME_LEN};
      tbl[9]  = '{8'h47, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FRAME_LEN};
      tbl[10] = '{8'h47, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FRAME_LEN};
      tbl[11] = '{8'h47, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[12] = '{8'h47, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[13] = '{8'h47, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[14] = '{8'h47, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FRAME_LEN};
      tbl[15] = '{8'h46, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, FRAME_LEN};

      for (int f = 0; f < NFRM; f++) begin
         phase = $sformatf("frame%0d", f);
         if (tbl[f].rst_before) begin
            do_reset();
         end
         send_frame(tbl[f]);
      end

      // Reset while locked and outputting payload: outputs must clear without a clock edge.
      phase = "mid_reset";
      send_frame('{8'h47, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 200});
      do_reset();

      // A false sync inside noise must not lead to lock once the expected window misses.
      phase = "false_hit";
      z  = '{dv:1'b0, d:1'b0, fs:1'b0, se:1'b0, lk:1'b0};
      sw = 8'h47;
      for (int i = 0; i < 20; i++) beat(1'b1, 1'b0, z);
      for (int i = 0; i < SYNC_LEN; i++) beat(1'b1, sw[7 - i], z);
      for (int i = 0; i < FRAME_LEN + SYNC_LEN + 20; i++) beat(1'b1, 1'b0, z);
      phase = "reacquire";
      send_frame('{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRAME_LEN});
      send_frame('{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRAME_LEN});
      send_frame('{8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRAME_LEN});
      send_frame('{8'h47, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_sync_descrambler.md
Name: frame_sync_descrambler

Overview:
- Receive-side partner of the transmit scrambler: it sits directly downstream of the 15-bit additive scrambler (x^15+x^14+1, seed 15'h57E5).
- Consumes a serial stream of frames. Each frame is an unscrambled SYNC_WORD followed by FRAME_LEN scrambled payload bits.
- Hunts for frame alignment, confirms lock, reseeds its LFSR at each frame boundary, and emits descrambled payload bits with framing flags.
- Transmit-side contract: the scrambler LFSR is held at seed until the first payload bit, enable is low during the sync word, and enable is high for every payload bit.

Parameters:
- SYNC_LEN, 8: sync word width in bits.
- SYNC_WORD, 8'h47: sync pattern, sent MSB first, unscrambled.
- FRAME_LEN, 1496: payload bits per frame (>= 16).
- LFSR_SEED, 15'h57E5: LFSR value loaded at the first payload bit.
- LOCK_CNT, 3: consecutive correctly spaced syncs required to declare lock (>= 1).
- UNLOCK_CNT, 2: consecutive missed syncs that drop lock (>= 1).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low (0 = reset).
- in_valid, input, 1: serial_in is valid this cycle; all state advances only on in_valid.
- serial_in, input, 1: received bit.
- data_out, output, 1: descrambled payload bit.
- data_valid, output, 1: data_out is valid; asserted only while locked, on payload bits.
- frame_start, output, 1: high with the first payload bit of a frame.
- locked, output, 1: alignment established.
- sync_err, output, 1: one-cycle pulse on a missed sync while locked.

Behaviour:
- Reset (rst=0, async): all outputs 0; LFSR = LFSR_SEED; sync shift register 0; bit counter 0; match and miss counters 0; state HUNT.
- LFSR: identical to the transmitter. Keystream bit k = lfsr[0]. Advance: lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}. It advances only on payload beats with in_valid.
- Descramble: data_out = serial_in ^ lfsr[0], registered. Latency is 1 clk from the in_valid beat. data_valid, frame_start and sync_err are registered the same way.
- Sync detect: shift register sr <= {sr[SYNC_LEN-2:0], serial_in} on every in_valid. A hit means sr, including the current bit, equals SYNC_WORD.
- Bit counter pos runs 0..FRAME_LEN-1 over payload bits. On pos=FRAME_LEN-1 it enters the sync window and counts SYNC_LEN bits before wrapping to payload pos 0.
- FSM:
  - HUNT: any hit -> CHECK; match counter = 1; LFSR = SEED; pos = 0 for the next beat.
  - CHECK: bits are counted but not output. At the sync window end:
    - hit: increment match counter; if it reaches LOCK_CNT -> LOCKED, else stay in CHECK; reseed in both cases.
    - miss: -> HUNT; clear match counter.
  - LOCKED: payload bits are output with data_valid=1; frame_start=1 at pos 0. At the sync window end:
    - hit: clear miss counter; reseed.
    - miss: pulse sync_err; increment miss counter; reseed anyway (flywheel). If the miss counter reaches UNLOCK_CNT -> HUNT, locked=0, and the next bit is treated as a hunt bit.
- locked=1 exactly while in LOCKED, registered.
- While in LOCKED, sync hits at any position other than the window end are ignored.
- Gaps: in_valid=0 freezes all state; registered data_valid and frame_start drop to 0 that cycle.
- Reset mid-frame: immediate return to the reset state; the next frame must re-acquire lock.
- With LOCK_CNT=1, the first hit goes straight to LOCKED.

Test Plan:
- Reset with rst=0 mid-stream -> all outputs 0 within the same cycle; after release, locked=0 until LOCK_CNT syncs are seen.
- Three frames: 8'h47, then 1496 bits of scrambler output for all-zero data (keystream starts 1,1,1...) -> locked rises after the 3rd sync. The 4th frame gives data_valid for 1496 beats, data_out all 0, frame_start on the first beat only.
- Locked, payload scrambled from 8'hA5 repeated -> data_out reproduces 1010_0101 repeatedly, 1 clk after each beat.
- Locked, corrupt one sync (8'h46) -> sync_err pulses once; locked stays 1; the next frame still descrambles correctly. Corrupt two consecutive syncs -> locked=0 after the 2nd.
- False 8'h47 inside the payload while in HUNT -> CHECK, then a miss at the expected window -> HUNT; locked never asserts.
- Random in_valid gaps (50% duty) over 4 frames -> identical data_out sequence to the gap-free run; no output on gap cycles.
